rr_arbiter_8: RTL and testbench
===============================

# rr_arbiter_8

Round-robin arbiter that shares one 8-way one-hot resource select among eight requesters. Each cycle it holds at most one grant, presented both as a 3-bit index and as its one-hot decode (the 3-to-8 decode of `gnt_idx` gated by `gnt_valid`). A grant is held until the owner releases it, a hold-time limit expires, or `enable` drops. It sits between requesting agents and the shared decoded-select datapath and sequences access to it.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive cycles one grant is held while others may wait. 0 disables the limit. Counter width is `$clog2(MAX_HOLD+1)`, minimum 1.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: arbitration enable. Low clears any grant at the next edge.
- `req` input 8: request vector, bit i is requester i, level-sensitive.
- `gnt` output 8: one-hot grant, all zero when `gnt_valid`=0.
- `gnt_idx` output 3: index of the current owner. Holds its last value when `gnt_valid`=0.
- `gnt_valid` output 1: a grant is active.

## Operation
- Internal state:
  - `state` ∈ {IDLE, BUSY}.
  - `ptr[2:0]`: highest-priority index for the next arbitration.
  - `hold_cnt`: cycles the current grant has been held.
- Reset (async, immediate, no clock needed): state=IDLE, `ptr`=0, `hold_cnt`=0, `gnt`=0, `gnt_idx`=0, `gnt_valid`=0.
- Pick function: first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … `ptr`+7, all mod 8 (wrap 7→0).
- IDLE:
  - If `enable`=1 and `req`≠0: register winner into `gnt_idx`, set `gnt_valid`=1, `hold_cnt`=1, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, release conditions evaluated each edge, in priority order:
  - `enable`=0: clear grant, `ptr`=`gnt_idx`+1, go to IDLE.
  - `req[gnt_idx]`=0 (voluntary release), or `MAX_HOLD`≠0 and `hold_cnt`==`MAX_HOLD` (forced release): set `ptr`=`gnt_idx`+1, then re-arbitrate on the same edge with the new `ptr`.
    - If `req`≠0: the winner gets the grant with no bubble cycle; `hold_cnt`=1.
    - Else: go to IDLE with `gnt_valid`=0.
  - No release condition: keep the grant; `hold_cnt` increments, saturating at its maximum.
- Forced release with the owner still requesting:
  - The owner ranks last because `ptr`=owner+1.
  - If it is the sole requester it is re-granted: `gnt_valid` stays 1, `gnt_idx` is unchanged, `hold_cnt` resets to 1.
- `ptr` changes only when a grant ends.
- `req` changes of non-owners never affect an active grant.

## Timing
- All outputs are registered.
- Latency: request seen at edge N in IDLE → `gnt` valid after edge N, i.e. 1 cycle.
- Owner deasserts `req` before edge N → next owner's `gnt` valid after edge N. Old and new grant never overlap; no idle cycle when others wait.
- With `MAX_HOLD`=M, contention, and the owner never releasing: each grant lasts exactly M cycles.
- `enable` low at edge N → `gnt`=0 after edge N. `enable` high again at edge N+k → new grant after that edge.
- `rst` asserted mid-grant → `gnt`=0 immediately (combinationally from the async reset). After deassertion, the first arbitration is at the first rising edge with `rst`=0.
- `gnt` is always one-hot or zero, never multi-hot.

## Test plan
- Reset: pulse `rst` between edges with `req`=8'hFF → `gnt`=8'h00, `gnt_valid`=0, `gnt_idx`=0 immediately; after release the first grant is idx 0 (`gnt`=8'h01).
- Wrap scan: `ptr`=0, `req`=8'b1010_0000 → `gnt`=8'h20, idx 5 after one edge. Drop `req[5]` → `gnt`=8'h80 next edge. Drop `req[7]` and assert `req[1]` → `gnt`=8'h02.
- Fairness with `MAX_HOLD`=4, `req`=8'hFF held → grant idx sequence 0,1,2,…,7,0, each exactly 4 cycles, no gaps.
- Sole requester, `MAX_HOLD`=4, `req`=8'h08 constant → `gnt`=8'h08 continuously, `gnt_valid` never drops, `hold_cnt` cycles 1→4→1.
- Enable drop: idx 2 granted, `req`=8'h0C, deassert `enable` one cycle → `gnt`=0 for that cycle. Re-assert → `gnt`=8'h08 (idx 3, since `ptr` advanced past 2).
- `MAX_HOLD`=0: `req`=8'h03, idx 0 owner never releases for 100 cycles → `gnt` stays 8'h01 throughout.

Source files
------------

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between eight requesting agents and the round-robin
// arbiter. The master side owns enable/req; the slave (arbiter) owns the grant.
interface rr_arbiter_8_if;
    logic       enable;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    modport master (
        output enable,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  enable,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with an optional hold-time limit. The grant is
// kept until the owner drops its request, the hold limit expires or enable
// falls. On release the next owner is chosen on the same edge, so there is no
// bubble cycle. All outputs are registered; gnt is the one-hot decode of
// gnt_idx gated by gnt_valid.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_8_if.slave bus
);
    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic             vld, vld_nxt;
    logic [7:0]       gnt_q, gnt_nxt;

    logic             rel_pick_found;
    logic [2:0]       rel_pick_idx;
    logic             new_pick_found;
    logic [2:0]       new_pick_idx;
    logic [2:0]       rel_ptr;
    logic             forced;

    // Returns {found, index} of the first requester at or after p, wrapping 7->0.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic       found;
        logic [2:0] win;
        logic [2:0] k;
        found = 1'b0;
        win   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            k = p + 3'(i);
            if (!found && r[k]) begin
                found = 1'b1;
                win   = k;
            end
        end
        return {found, win};
    endfunction

    // Candidate winners: from ptr for a fresh grant, from owner+1 after a release.
    always_comb begin
        rel_ptr = idx + 3'd1;
        {new_pick_found, new_pick_idx} = pick(bus.req, ptr);
        {rel_pick_found, rel_pick_idx} = pick(bus.req, rel_ptr);
        forced = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
    end

    // Next-state and next-grant logic for the IDLE/BUSY controller.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = hold_cnt;
        idx_nxt   = idx;
        vld_nxt   = vld;
        case (state)
            IDLE: begin
                if (bus.enable && new_pick_found) begin
                    idx_nxt   = new_pick_idx;
                    vld_nxt   = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!bus.enable) begin
                    vld_nxt   = 1'b0;
                    ptr_nxt   = rel_ptr;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (!bus.req[idx] || forced) begin
                    // Owner ranks last after release, so a still-requesting
                    // owner only wins again when nobody else is waiting.
                    ptr_nxt = rel_ptr;
                    if (rel_pick_found) begin
                        idx_nxt = rel_pick_idx;
                        vld_nxt = 1'b1;
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        vld_nxt   = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else if (hold_cnt != {CNT_W{1'b1}}) begin
                    cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                vld_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
        gnt_nxt = vld_nxt ? (8'b0000_0001 << idx_nxt) : 8'h00;
    end

    // Controller and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            hold_cnt <= '0;
            idx      <= 3'd0;
            vld      <= 1'b0;
            gnt_q    <= 8'h00;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= cnt_nxt;
            idx      <= idx_nxt;
            vld      <= vld_nxt;
            gnt_q    <= gnt_nxt;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx;
    assign bus.gnt_valid = vld;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: three instances cover the default hold
// limit (16), a short limit (4) and the unlimited case (0).
module tb_rr_arbiter_8;
    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    rr_arbiter_8_if b16 ();
    rr_arbiter_8_if b4 ();
    rr_arbiter_8_if b0 ();

    rr_arbiter_8 d16 (.clk(clk), .rst(rst), .bus(b16.slave));
    rr_arbiter_8 #(.MAX_HOLD(4)) d4 (.clk(clk), .rst(rst), .bus(b4.slave));
    rr_arbiter_8 #(.MAX_HOLD(0)) d0 (.clk(clk), .rst(rst), .bus(b0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b1;
        b16.enable = 1'b0; b16.req = 8'h00;
        b4.enable  = 1'b0; b4.req  = 8'h00;
        b0.enable  = 1'b0; b0.req  = 8'h00;

        // Reset state held across an edge with all requests present.
        b16.enable = 1'b1;
        b16.req    = 8'hFF;
        tick();
        chk("rst_gnt", b16.gnt, 8'h00);
        chk("rst_valid", b16.gnt_valid, 1'b0);
        chk("rst_idx", b16.gnt_idx, 3'd0);

        rst = 1'b0;
        tick();
        chk("first_gnt", b16.gnt, 8'h01);
        chk("first_idx", b16.gnt_idx, 3'd0);
        chk("first_valid", b16.gnt_valid, 1'b1);

        // Owner 0 drops: next owner 1 without a bubble.
        b16.req = 8'hFE;
        tick();
        chk("handoff_gnt", b16.gnt, 8'h02);
        chk("handoff_idx", b16.gnt_idx, 3'd1);

        // Asynchronous reset mid-grant clears outputs before any edge.
        rst = 1'b1;
        #2;
        chk("async_rst_gnt", b16.gnt, 8'h00);
        chk("async_rst_valid", b16.gnt_valid, 1'b0);
        chk("async_rst_idx", b16.gnt_idx, 3'd0);
        rst = 1'b0;
        #2;
        b16.req = 8'hFF;
        tick();
        chk("post_rst_gnt", b16.gnt, 8'h01);
        chk("post_rst_idx", b16.gnt_idx, 3'd0);

        // Wrap scan from ptr=0.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        b16.req = 8'b1010_0000;
        tick();
        chk("wrap_gnt5", b16.gnt, 8'h20);
        chk("wrap_idx5", b16.gnt_idx, 3'd5);
        b16.req = 8'h80;
        tick();
        chk("wrap_gnt7", b16.gnt, 8'h80);
        chk("wrap_idx7", b16.gnt_idx, 3'd7);
        b16.req = 8'h02;
        tick();
        chk("wrap_gnt1", b16.gnt, 8'h02);
        chk("wrap_idx1", b16.gnt_idx, 3'd1);

        // Enable drop with idx 2 owning and idx 3 waiting.
        b16.req = 8'h0C;
        tick();
        chk("en_gnt2", b16.gnt, 8'h04);
        chk("en_idx2", b16.gnt_idx, 3'd2);
        b16.enable = 1'b0;
        tick();
        chk("en_off_gnt", b16.gnt, 8'h00);
        chk("en_off_valid", b16.gnt_valid, 1'b0);
        chk("en_off_idx_hold", b16.gnt_idx, 3'd2);
        b16.enable = 1'b1;
        tick();
        chk("en_on_gnt", b16.gnt, 8'h08);
        chk("en_on_idx", b16.gnt_idx, 3'd3);

        // Non-owner request changes do not disturb the grant.
        b16.req = 8'h58;
        tick();
        chk("nonowner_gnt", b16.gnt, 8'h08);
        tick();
        chk("nonowner_gnt2", b16.gnt, 8'h08);
        b16.enable = 1'b0;
        b16.req    = 8'h00;

        // Fairness with MAX_HOLD=4: each index holds exactly 4 cycles.
        b4.enable = 1'b1;
        b4.req    = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("fair_idx_k%0d_c%0d", k, c), b4.gnt_idx, 32'(k % 8));
                chk($sformatf("fair_gnt_k%0d_c%0d", k, c), b4.gnt, 32'(8'h01 << (k % 8)));
                chk($sformatf("fair_valid_k%0d_c%0d", k, c), b4.gnt_valid, 1'b1);
                tick();
            end
        end

        // Sole requester under MAX_HOLD=4 is re-granted with no gap.
        b4.req = 8'h08;
        tick();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("sole_gnt_c%0d", c), b4.gnt, 8'h08);
            chk($sformatf("sole_valid_c%0d", c), b4.gnt_valid, 1'b1);
            chk($sformatf("sole_cnt_c%0d", c), 32'(d4.hold_cnt), 32'((c % 4) + 1));
            tick();
        end
        b4.enable = 1'b0;
        b4.req    = 8'h00;

        // MAX_HOLD=0: owner 0 keeps the grant indefinitely.
        b0.enable = 1'b1;
        b0.req    = 8'h03;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk($sformatf("nolimit_gnt_c%0d", c), b0.gnt, 8'h01);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
